cpu_mem_responder: RTL



---
 rtl/cpu_mem_responder_if.sv | 34 +++
 rtl/cpu_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder_if.sv
// CPU <-> memory responder bundle: fetch request/response and data request/read-data channels.
// Pure wiring, no latency of its own.
// Every channel is valid/ready; master is the CPU side, slave the memory side.
interface cpu_mem_responder_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ready,
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Inst_Req_Ready, Instruction, Inst_Valid,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready,
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Inst_Req_Ready, Instruction, Inst_Valid,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder serving CPU fetches and data accesses from one word RAM, one transaction at a time.
// Latency: ready 1 cycle after request; response valid RESP_LAT+1 cycles after the request handshake.
// Backpressure: responses hold valid/data until ready; CPU_MEM_RANDOM_DELAY_EN adds LFSR-driven stalls.
module cpu_mem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          RESP_LAT   = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  cpu_mem_responder_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] I_ACK  = 3'd1;
  localparam logic [2:0] I_DLY  = 3'd2;
  localparam logic [2:0] I_RESP = 3'd3;
  localparam logic [2:0] R_ACK  = 3'd4;
  localparam logic [2:0] R_DLY  = 3'd5;
  localparam logic [2:0] R_RESP = 3'd6;
  localparam logic [2:0] W_ACK  = 3'd7;

  localparam logic [4:0] LAT = 5'(RESP_LAT);

  logic [2:0]            state, state_n;
  logic [4:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n, rd_idx;
  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic                  ld_inst, ld_rd, wr_en;
  logic [2:0]            ack_stall;
  logic [4:0]            dly_total;
  logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];

  // Word indices; upper address bits are dropped so addresses wrap.
  assign i_idx = bus.PC[ADDR_WIDTH+1:2];
  assign d_idx = bus.Address[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.PC[31:ADDR_WIDTH+2], bus.PC[1:0],
                              bus.Address[31:ADDR_WIDTH+2], bus.Address[1:0]};

`ifdef CPU_MEM_RANDOM_DELAY_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running to draw stall lengths.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign ack_stall = lfsr[2:0];
  assign dly_total = LAT + {2'b00, lfsr[5:3]};
`else
  assign ack_stall = 3'd0;
  assign dly_total = LAT;
`endif

  // Next-state decode; cnt doubles as the ready-withhold counter in ACK and the delay counter in DLY.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_q;
    rd_idx  = addr_q;
    ld_inst = 1'b0;
    ld_rd   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = {2'b00, ack_stall};
        if (bus.MemWrite)            state_n = W_ACK;
        else if (bus.MemRead)        state_n = R_ACK;
        else if (bus.Inst_Req_Valid) state_n = I_ACK;
      end
      I_ACK: begin
        if (!bus.Inst_Req_Valid) state_n = IDLE;
        else if (cnt != 5'd0)    cnt_n = cnt - 5'd1;
        else if (bus.Inst_Req_Ready) begin
          addr_n = i_idx;
          if (dly_total == 5'd0) begin
            state_n = I_RESP;
            rd_idx  = i_idx;
            ld_inst = 1'b1;
          end else begin
            state_n = I_DLY;
            cnt_n   = dly_total;
          end
        end
      end
      I_DLY: begin
        if (cnt <= 5'd1) begin
          state_n = I_RESP;
          ld_inst = 1'b1;
        end else cnt_n = cnt - 5'd1;
      end
      I_RESP: if (bus.Inst_Ready) state_n = IDLE;
      R_ACK: begin
        if (!bus.MemRead)     state_n = IDLE;
        else if (cnt != 5'd0) cnt_n = cnt - 5'd1;
        else if (bus.Mem_Req_Ready) begin
          addr_n = d_idx;
          if (dly_total == 5'd0) begin
            state_n = R_RESP;
            rd_idx  = d_idx;
            ld_rd   = 1'b1;
          end else begin
            state_n = R_DLY;
            cnt_n   = dly_total;
          end
        end
      end
      R_DLY: begin
        if (cnt <= 5'd1) begin
          state_n = R_RESP;
          ld_rd   = 1'b1;
        end else cnt_n = cnt - 5'd1;
      end
      R_RESP: if (bus.Read_data_Ready) state_n = IDLE;
      W_ACK: begin
        if (!bus.MemWrite)    state_n = IDLE;
        else if (cnt != 5'd0) cnt_n = cnt - 5'd1;
        else if (bus.Mem_Req_Ready) begin
          wr_en   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs; ready/valid are decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= 5'd0;
      addr_q              <= '0;
      bus.Inst_Req_Ready  <= 1'b0;
      bus.Mem_Req_Ready   <= 1'b0;
      bus.Inst_Valid      <= 1'b0;
      bus.Read_data_Valid <= 1'b0;
      bus.Instruction     <= 32'h0;
      bus.Read_data       <= 32'h0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      addr_q              <= addr_n;
      bus.Inst_Req_Ready  <= (state_n == I_ACK) && (cnt_n == 5'd0);
      bus.Mem_Req_Ready   <= ((state_n == R_ACK) || (state_n == W_ACK)) && (cnt_n == 5'd0);
      bus.Inst_Valid      <= (state_n == I_RESP);
      bus.Read_data_Valid <= (state_n == R_RESP);
      if (ld_inst) bus.Instruction <= mem[rd_idx];
      if (ld_rd)   bus.Read_data   <= mem[rd_idx];
    end
  end

  // Byte-lane RAM write on the W_ACK handshake; contents survive reset, a reset edge suppresses the write.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.Write_strb[b]) mem[d_idx][8*b +: 8] <= bus.Write_data[8*b +: 8];
      end
    end
  end

endmodule
